// File: rtl/alu_runner_pkg.sv
// -----------------------------------------------------------------------------
// alu_runner_pkg
// Shared types for the ALU vector runner.
//   vec_t   : one operand vector {x, y, op} as written by the host
//   res_t   : one captured result {z, flags}
//   state_t : run sequencer states
//   OVF/EQ/ZERO : bit positions inside the 3-bit ALU flag word
// -----------------------------------------------------------------------------
package alu_runner_pkg;

  localparam int OVF  = 2;
  localparam int EQ   = 1;
  localparam int ZERO = 0;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [2:0]  op;
  } vec_t;

  typedef struct packed {
    logic [31:0] z;
    logic [2:0]  flags;
  } res_t;

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    WAIT,
    CAPTURE
  } state_t;

endpackage

// File: rtl/alu_runner_regfile.sv
// -----------------------------------------------------------------------------
// alu_runner_regfile
// DEPTH x WIDTH storage with one synchronous write port and one registered
// read port. The array itself is never reset; only the read register is.
// Ports:
//   clk       : clock
//   rst_n     : synchronous active-low reset of the read register
//   i_we      : write enable
//   i_waddr   : write address
//   i_wdata   : write data
//   i_raddr   : read address, sampled on the rising edge
//   i_rd_zero : force the read register to zero instead of loading memory
//   o_rdata   : registered read data (one cycle latency)
// -----------------------------------------------------------------------------
module alu_runner_regfile #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  input  logic                     i_rd_zero,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Write-first on an address collision: a vector written in the same cycle
  // a run starts must be seen by the first APPLY.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (i_rd_zero) begin
      r_rdata <= '0;
    end else if (i_we && (i_waddr == i_raddr)) begin
      r_rdata <= i_wdata;
    end else begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/alu_vector_runner.sv
// -----------------------------------------------------------------------------
// alu_vector_runner
// Buffers up to DEPTH operand vectors from the host, plays them one by one
// onto a combinational ALU when started, holds each for SETTLE cycles, and
// stores {z, flags} per vector into a result buffer readable by index.
// Ports:
//   okClk, rst_n          : clock, synchronous active-low reset
//   clear                 : empty both buffers, abort any run (highest priority)
//   load_valid/x/y/op     : append a vector at entry 'count'
//   load_ready            : idle and not full (combinational)
//   start                 : begin a run over entries 0..count-1
//   busy, done, count     : run status, sticky completion, vectors held
//   alu_x/alu_y/alu_op    : registered operands driving the ALU
//   alu_z, alu_flags      : ALU result {overflow, equal, zero}
//   rd_idx, rd_z, rd_flags: registered result readback (0 beyond count)
// -----------------------------------------------------------------------------
module alu_vector_runner
  import alu_runner_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int SETTLE = 2
) (
  input  logic                       okClk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       load_valid,
  input  logic [31:0]                load_x,
  input  logic [31:0]                load_y,
  input  logic [2:0]                 load_op,
  output logic                       load_ready,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [31:0]                alu_x,
  output logic [31:0]                alu_y,
  output logic [2:0]                 alu_op,
  input  logic [31:0]                alu_z,
  input  logic [2:0]                 alu_flags,
  input  logic [$clog2(DEPTH)-1:0]   rd_idx,
  output logic [31:0]                rd_z,
  output logic [2:0]                 rd_flags
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int SW = $clog2(SETTLE+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  state_t        r_state, w_state_next;
  logic [IW-1:0] r_idx, w_idx_next;
  logic [CW-1:0] r_count, w_count_next;
  logic [SW-1:0] r_settle, w_settle_next;
  logic          r_done, w_done_next;
  vec_t          r_alu, w_alu_next;

  logic          w_load_accept;
  logic          w_res_we;
  logic          w_last;
  logic          w_rd_out_of_range;
  vec_t          w_load_vec;
  vec_t          w_vec_rd;
  res_t          w_res_wr;
  res_t          w_res_rd;

  assign load_ready    = (r_state == IDLE) && (r_count < DEPTH_C);
  assign w_load_accept = load_valid && load_ready && !clear;
  assign w_last        = ((CW'(r_idx) + CW'(1)) == r_count);
  assign w_load_vec    = {load_x, load_y, load_op};
  assign w_res_wr      = {alu_z, alu_flags[OVF], alu_flags[EQ], alu_flags[ZERO]};
  assign w_rd_out_of_range = !(CW'(rd_idx) < r_count);

  // Vector buffer is read at the *next* run index so that the entry for
  // r_idx is already sitting in the read register during APPLY.
  alu_runner_regfile #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(vec_t))
  ) u_vec_buf (
    .clk       (okClk),
    .rst_n     (rst_n),
    .i_we      (w_load_accept),
    .i_waddr   (r_count[IW-1:0]),
    .i_wdata   (w_load_vec),
    .i_raddr   (w_idx_next),
    .i_rd_zero (1'b0),
    .o_rdata   (w_vec_rd)
  );

  alu_runner_regfile #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(res_t))
  ) u_res_buf (
    .clk       (okClk),
    .rst_n     (rst_n),
    .i_we      (w_res_we),
    .i_waddr   (r_idx),
    .i_wdata   (w_res_wr),
    .i_raddr   (rd_idx),
    .i_rd_zero (w_rd_out_of_range),
    .o_rdata   (w_res_rd)
  );

  always_ff @(posedge okClk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_count  <= '0;
      r_settle <= '0;
      r_done   <= 1'b0;
      r_alu    <= '0;
    end else begin
      r_state  <= w_state_next;
      r_idx    <= w_idx_next;
      r_count  <= w_count_next;
      r_settle <= w_settle_next;
      r_done   <= w_done_next;
      r_alu    <= w_alu_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_idx_next    = r_idx;
    w_count_next  = r_count;
    w_settle_next = r_settle;
    w_done_next   = r_done;
    w_alu_next    = r_alu;
    w_res_we      = 1'b0;

    if (clear) begin
      // ALU operands intentionally keep their last values.
      w_state_next = IDLE;
      w_idx_next   = '0;
      w_count_next = '0;
      w_done_next  = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_load_accept) begin
            w_count_next = r_count + CW'(1);
          end
          // A load in the same cycle as start joins the run.
          if (start) begin
            if (w_count_next != '0) begin
              w_done_next  = 1'b0;
              w_idx_next   = '0;
              w_state_next = APPLY;
            end else begin
              w_done_next  = 1'b1;
            end
          end
        end
        APPLY: begin
          w_alu_next    = w_vec_rd;
          w_settle_next = SW'(SETTLE);
          w_state_next  = WAIT;
        end
        WAIT: begin
          w_settle_next = r_settle - SW'(1);
          if (r_settle == SW'(1)) begin
            w_state_next = CAPTURE;
          end
        end
        CAPTURE: begin
          w_res_we = 1'b1;
          if (w_last) begin
            w_state_next = IDLE;
            w_done_next  = 1'b1;
          end else begin
            w_idx_next   = r_idx + IW'(1);
            w_state_next = APPLY;
          end
        end
        default: begin
          w_state_next = IDLE;
        end
      endcase
    end
  end

  assign busy     = (r_state != IDLE);
  assign done     = r_done;
  assign count    = r_count;
  assign alu_x    = r_alu.x;
  assign alu_y    = r_alu.y;
  assign alu_op   = r_alu.op;
  assign rd_z     = w_res_rd.z;
  assign rd_flags = w_res_rd.flags;

endmodule
